assoc_cache_array: RTL and testbench

Set-associative tag array with built-in hit detection, per-line valid bits, replacement-victim selection and a multi-cycle flush sequencer. It is the parametrised successor of the per-way tag RAM array in the cache datapath. It sits between the cache controller FSM and the data arrays: the controller issues lookups and fills, and this block answers with hit way, victim way and victim validity.

---
 rtl/assoc_cache_array_pkg.sv | 20 ++
 rtl/assoc_cache_array_if.sv | 37 +++
 rtl/assoc_cache_array_repl_policy.sv | 94 +++++++++
 rtl/assoc_cache_array.sv | 131 +++++++++++++
 tb/tb_assoc_cache_array.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/assoc_cache_array_pkg.sv
// Shared types for the set-associative tag array: flush FSM states and a
// one-hot to binary index helper.
package assoc_cache_array_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  // Returns the index of the highest set bit; zero when nothing is set.
  function automatic int unsigned onehot_to_index(input logic [63:0] onehot);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < 64; i++) begin
      if (onehot[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/assoc_cache_array_if.sv
// Lookup/result/fill/flush bus between the cache controller (master) and
// the tag array (slave).
interface assoc_cache_array_if #(
  parameter int TAG_WIDTH             = 20,
  parameter int NUMBER_WAYS           = 4,
  parameter int SET_PTR_WIDTH_IN_BITS = 6
);
  logic                             lookup_valid_in;
  logic                             lookup_ready_out;
  logic [SET_PTR_WIDTH_IN_BITS-1:0] lookup_set_in;
  logic [TAG_WIDTH-1:0]             lookup_tag_in;
  logic                             result_valid_out;
  logic                             result_hit_out;
  logic [NUMBER_WAYS-1:0]           result_way_out;
  logic [NUMBER_WAYS-1:0]           result_victim_out;
  logic                             result_victim_valid_out;
  logic                             fill_en_in;
  logic [SET_PTR_WIDTH_IN_BITS-1:0] fill_set_in;
  logic [NUMBER_WAYS-1:0]           fill_way_in;
  logic [TAG_WIDTH-1:0]             fill_tag_in;
  logic                             flush_in;
  logic                             busy_out;

  modport master (
    output lookup_valid_in, lookup_set_in, lookup_tag_in,
           fill_en_in, fill_set_in, fill_way_in, fill_tag_in, flush_in,
    input  lookup_ready_out, result_valid_out, result_hit_out, result_way_out,
           result_victim_out, result_victim_valid_out, busy_out
  );

  modport slave (
    input  lookup_valid_in, lookup_set_in, lookup_tag_in,
           fill_en_in, fill_set_in, fill_way_in, fill_tag_in, flush_in,
    output lookup_ready_out, result_valid_out, result_hit_out, result_way_out,
           result_victim_out, result_victim_valid_out, busy_out
  );
endinterface

// File: rtl/assoc_cache_array_repl_policy.sv
// Per-set replacement state and victim selection. ASSOC_CACHE_ARRAY_PLRU_EN
// selects tree pseudo-LRU; otherwise a per-set round-robin pointer is used.
module assoc_repl_policy
  import assoc_cache_array_pkg::*;
#(
  parameter int NUMBER_WAYS           = 4,
  parameter int NUMBER_SETS           = 64,
  parameter int SET_PTR_WIDTH_IN_BITS = 6,
  parameter int WAY_PTR_WIDTH_IN_BITS = 2
) (
  input  logic                             clk_in,
  input  logic                             reset_in,
  input  logic                             clear_en,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0] clear_set,
  input  logic                             fill_en,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0] fill_set,
  input  logic [NUMBER_WAYS-1:0]           fill_way,
  input  logic                             hit_en,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0] hit_set,
  input  logic [NUMBER_WAYS-1:0]           hit_way,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0] read_set,
  output logic [NUMBER_WAYS-1:0]           victim
);
  localparam int W = WAY_PTR_WIDTH_IN_BITS;

`ifdef ASSOC_CACHE_ARRAY_PLRU_EN
  // Heap-ordered tree: node n has children 2n+1 (lower half) and 2n+2.
  // A node value of 1 steers the victim search to the upper half.
  logic [NUMBER_SETS-1:0][NUMBER_WAYS-2:0] tree_q;

  function automatic logic [NUMBER_WAYS-2:0] plru_touch(
    input logic [NUMBER_WAYS-2:0] tree, input logic [W-1:0] way);
    logic [NUMBER_WAYS-2:0] t;
    logic [W-1:0] node, path;
    logic b;
    t    = tree;
    node = '0;
    path = way;
    for (int unsigned l = 0; l < W; l++) begin
      b       = path[W-1];
      path    = path << 1;
      t[node] = ~b;
      node    = (node << 1) + W'(1) + W'(b);
    end
    return t;
  endfunction

  function automatic logic [W-1:0] plru_victim(input logic [NUMBER_WAYS-2:0] tree);
    logic [W-1:0] node, v;
    logic b;
    node = '0;
    v    = '0;
    for (int unsigned l = 0; l < W; l++) begin
      b    = tree[node];
      v    = (v << 1) | W'(b);
      node = (node << 1) + W'(1) + W'(b);
    end
    return v;
  endfunction

  logic [W-1:0] fill_idx, hit_idx;
  assign fill_idx = W'(onehot_to_index(64'(fill_way)));
  assign hit_idx  = W'(onehot_to_index(64'(hit_way)));

  // Later non-blocking writes win: clear over fill over hit on the same set.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      tree_q <= '0;
    end else begin
      if (hit_en)   tree_q[hit_set]   <= plru_touch(tree_q[hit_set], hit_idx);
      if (fill_en)  tree_q[fill_set]  <= plru_touch(tree_q[fill_set], fill_idx);
      if (clear_en) tree_q[clear_set] <= '0;
    end
  end

  assign victim = NUMBER_WAYS'(1) << plru_victim(tree_q[read_set]);
`else
  logic [NUMBER_SETS-1:0][W-1:0] ptr_q;
  logic unused_hit;
  assign unused_hit = ^{hit_en, hit_set, hit_way, fill_way};

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      ptr_q <= '0;
    end else begin
      if (fill_en)  ptr_q[fill_set]  <= ptr_q[fill_set] + W'(1);
      if (clear_en) ptr_q[clear_set] <= '0;
    end
  end

  assign victim = NUMBER_WAYS'(1) << ptr_q[read_set];
`endif

endmodule

// File: rtl/assoc_cache_array.sv
// Set-associative tag array with hit detection, victim selection and a
// one-set-per-cycle flush sweep. Optional macro: ASSOC_CACHE_ARRAY_PLRU_EN.
module assoc_cache_array
  import assoc_cache_array_pkg::*;
#(
  parameter int TAG_WIDTH             = 20,
  parameter int NUMBER_WAYS           = 4,
  parameter int NUMBER_SETS           = 64,
  parameter int SET_PTR_WIDTH_IN_BITS = 6,
  parameter int WAY_PTR_WIDTH_IN_BITS = 2
) (
  input logic                clk_in,
  input logic                reset_in,
  assoc_cache_array_if.slave bus
);
  localparam int S = SET_PTR_WIDTH_IN_BITS;

  state_t state_q, state_d;
  logic [S-1:0] cnt_q, cnt_d;
  logic clear_en, accept, fill_go;

  logic [TAG_WIDTH-1:0] tag_q [NUMBER_WAYS][NUMBER_SETS];
  logic [NUMBER_SETS-1:0][NUMBER_WAYS-1:0] valid_q;
  logic [NUMBER_WAYS-1:0] set_valid, invalid, hit_vec, repl_victim, victim_sel;
  logic victim_valid_sel;

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clear_en = 1'b0;
    unique case (state_q)
      IDLE: if (bus.flush_in) begin
        state_d = FLUSH;
        cnt_d   = '0;
      end
      FLUSH: begin
        clear_en = 1'b1;
        cnt_d    = cnt_q + S'(1);
        if (cnt_q == S'(NUMBER_SETS - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy_out         = (state_q == FLUSH);
  assign bus.lookup_ready_out = (state_q == IDLE);
  assign accept  = bus.lookup_valid_in && bus.lookup_ready_out;
  assign fill_go = bus.fill_en_in && (state_q == IDLE);

  for (genvar w = 0; w < NUMBER_WAYS; w++) begin : g_tag
    always_ff @(posedge clk_in) begin
      if (fill_go && bus.fill_way_in[w]) tag_q[w][bus.fill_set_in] <= bus.fill_tag_in;
    end
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      valid_q <= '0;
    end else begin
      if (fill_go)  valid_q[bus.fill_set_in] <= valid_q[bus.fill_set_in] | bus.fill_way_in;
      if (clear_en) valid_q[cnt_q] <= '0;
    end
  end

  // Compare and victim pick read pre-edge contents, giving read-before-write
  // against a same-cycle fill.
  always_comb begin
    set_valid = valid_q[bus.lookup_set_in];
    invalid   = ~set_valid;
    hit_vec   = '0;
    for (int unsigned w = 0; w < NUMBER_WAYS; w++) begin
      hit_vec[w] = set_valid[w] && (tag_q[w][bus.lookup_set_in] == bus.lookup_tag_in);
    end
    if (|invalid) begin
      victim_sel       = invalid & (~invalid + NUMBER_WAYS'(1));
      victim_valid_sel = 1'b0;
    end else begin
      victim_sel       = repl_victim;
      victim_valid_sel = 1'b1;
    end
  end

  assoc_repl_policy #(
    .NUMBER_WAYS          (NUMBER_WAYS),
    .NUMBER_SETS          (NUMBER_SETS),
    .SET_PTR_WIDTH_IN_BITS(SET_PTR_WIDTH_IN_BITS),
    .WAY_PTR_WIDTH_IN_BITS(WAY_PTR_WIDTH_IN_BITS)
  ) u_repl (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .clear_en (clear_en),
    .clear_set(cnt_q),
    .fill_en  (fill_go),
    .fill_set (bus.fill_set_in),
    .fill_way (bus.fill_way_in),
    .hit_en   (accept && (|hit_vec)),
    .hit_set  (bus.lookup_set_in),
    .hit_way  (hit_vec),
    .read_set (bus.lookup_set_in),
    .victim   (repl_victim)
  );

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      bus.result_valid_out        <= 1'b0;
      bus.result_hit_out          <= 1'b0;
      bus.result_way_out          <= '0;
      bus.result_victim_out       <= '0;
      bus.result_victim_valid_out <= 1'b0;
    end else begin
      bus.result_valid_out <= accept;
      if (accept) begin
        bus.result_hit_out          <= |hit_vec;
        bus.result_way_out          <= hit_vec;
        bus.result_victim_out       <= victim_sel;
        bus.result_victim_valid_out <= victim_valid_sel;
      end
    end
  end

endmodule

// File: tb/tb_assoc_cache_array.sv
// Directed bench for assoc_cache_array; victim expectations follow
// ASSOC_CACHE_ARRAY_PLRU_EN when it is defined for the build.
module tb_assoc_cache_array;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_checks = 0;
  int n_fail = 0;

  assoc_cache_array_if #(.TAG_WIDTH(20), .NUMBER_WAYS(4), .SET_PTR_WIDTH_IN_BITS(6)) bus ();

  assoc_cache_array #(
    .TAG_WIDTH(20), .NUMBER_WAYS(4), .NUMBER_SETS(64),
    .SET_PTR_WIDTH_IN_BITS(6), .WAY_PTR_WIDTH_IN_BITS(2)
  ) dut (
    .clk_in  (clk),
    .reset_in(rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100us;
    $display("FAIL timeout: simulation did not reach end of test");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  task automatic do_lookup(input logic [5:0] set, input logic [19:0] tag);
    @(negedge clk);
    bus.lookup_valid_in = 1'b1;
    bus.lookup_set_in   = set;
    bus.lookup_tag_in   = tag;
    @(posedge clk);
    #1;
    bus.lookup_valid_in = 1'b0;
  endtask

  task automatic do_fill(input logic [5:0] set, input logic [3:0] way, input logic [19:0] tag);
    @(negedge clk);
    bus.fill_en_in  = 1'b1;
    bus.fill_set_in = set;
    bus.fill_way_in = way;
    bus.fill_tag_in = tag;
    @(posedge clk);
    #1;
    bus.fill_en_in = 1'b0;
  endtask

  int busy_cycles;
  bit ready_seen, result_seen;

  initial begin
    bus.lookup_valid_in = 1'b0;
    bus.lookup_set_in   = '0;
    bus.lookup_tag_in   = '0;
    bus.fill_en_in      = 1'b0;
    bus.fill_set_in     = '0;
    bus.fill_way_in     = '0;
    bus.fill_tag_in     = '0;
    bus.flush_in        = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_result_valid", bus.result_valid_out, 0);
    check("rst_hit", bus.result_hit_out, 0);
    check("rst_way", bus.result_way_out, 0);
    check("rst_victim", bus.result_victim_out, 0);
    check("rst_victim_valid", bus.result_victim_valid_out, 0);
    check("rst_busy", bus.busy_out, 0);
    check("rst_ready", bus.lookup_ready_out, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Miss on empty set, then single-cycle result pulse
    do_lookup(6'd5, 20'h12345);
    check("miss_valid", bus.result_valid_out, 1);
    check("miss_hit", bus.result_hit_out, 0);
    check("miss_victim", bus.result_victim_out, 4'b0001);
    check("miss_victim_valid", bus.result_victim_valid_out, 0);
    @(posedge clk);
    #1;
    check("result_pulse_end", bus.result_valid_out, 0);

    // Fill then hit / near-miss
    do_fill(6'd5, 4'b0100, 20'hABCDE);
    do_lookup(6'd5, 20'hABCDE);
    check("fill_hit", bus.result_hit_out, 1);
    check("fill_hit_way", bus.result_way_out, 4'b0100);
    do_lookup(6'd5, 20'hABCDF);
    check("near_miss_hit", bus.result_hit_out, 0);
    check("near_miss_way", bus.result_way_out, 0);
    check("near_miss_victim", bus.result_victim_out, 4'b0001);
    check("near_miss_vv", bus.result_victim_valid_out, 0);

    // Full set replacement choice
    for (int i = 0; i < 4; i++) begin
      do_fill(6'd3, 4'(1 << i), 20'h00300 + 20'(i));
    end
    do_lookup(6'd3, 20'h00302);
    check("set3_hit_w2", bus.result_way_out, 4'b0100);
    do_lookup(6'd3, 20'h00303);
    check("set3_hit_w3", bus.result_way_out, 4'b1000);
    do_lookup(6'd3, 20'h00300);
    check("set3_hit_w0", bus.result_way_out, 4'b0001);
    do_lookup(6'd3, 20'h003FF);
    check("set3_miss_hit", bus.result_hit_out, 0);
    check("set3_miss_vv", bus.result_victim_valid_out, 1);
`ifdef ASSOC_CACHE_ARRAY_PLRU_EN
    check("set3_victim", bus.result_victim_out, 4'b0100);
`else
    check("set3_victim", bus.result_victim_out, 4'b0001);
`endif
    do_fill(6'd3, 4'b0001, 20'h00310);
    do_lookup(6'd3, 20'h003FF);
`ifdef ASSOC_CACHE_ARRAY_PLRU_EN
    check("set3_victim_refill", bus.result_victim_out, 4'b0100);
`else
    check("set3_victim_refill", bus.result_victim_out, 4'b0010);
`endif

    // Back-to-back lookups
    @(negedge clk);
    bus.lookup_valid_in = 1'b1;
    bus.lookup_set_in   = 6'd5;
    bus.lookup_tag_in   = 20'hABCDE;
    @(posedge clk);
    #1;
    check("b2b_first_hit", bus.result_hit_out, 1);
    bus.lookup_tag_in = 20'h12345;
    @(posedge clk);
    #1;
    bus.lookup_valid_in = 1'b0;
    check("b2b_second_valid", bus.result_valid_out, 1);
    check("b2b_second_hit", bus.result_hit_out, 0);

    // Same-cycle fill and lookup: read-before-write
    @(negedge clk);
    bus.fill_en_in      = 1'b1;
    bus.fill_set_in     = 6'd7;
    bus.fill_way_in     = 4'b0001;
    bus.fill_tag_in     = 20'h00077;
    bus.lookup_valid_in = 1'b1;
    bus.lookup_set_in   = 6'd7;
    bus.lookup_tag_in   = 20'h00077;
    @(posedge clk);
    #1;
    bus.fill_en_in      = 1'b0;
    bus.lookup_valid_in = 1'b0;
    check("rbw_hit", bus.result_hit_out, 0);
    check("rbw_victim", bus.result_victim_out, 4'b0001);
    do_lookup(6'd7, 20'h00077);
    check("rbw_next_hit", bus.result_hit_out, 1);
    check("rbw_next_way", bus.result_way_out, 4'b0001);

    // Flush sweep, with a fill issued alongside flush_in
    do_fill(6'd0, 4'b0010, 20'hAAAAA);
    do_fill(6'd63, 4'b0010, 20'hBBBBB);
    do_lookup(6'd63, 20'hBBBBB);
    check("set63_hit_preflush", bus.result_way_out, 4'b0010);
    @(negedge clk);
    bus.flush_in    = 1'b1;
    bus.fill_en_in  = 1'b1;
    bus.fill_set_in = 6'd10;
    bus.fill_way_in = 4'b0001;
    bus.fill_tag_in = 20'h00010;
    @(posedge clk);
    #1;
    bus.flush_in        = 1'b0;
    bus.fill_en_in      = 1'b0;
    bus.lookup_valid_in = 1'b1;
    bus.lookup_set_in   = 6'd0;
    bus.lookup_tag_in   = 20'hAAAAA;
    busy_cycles = 0;
    ready_seen  = 1'b0;
    result_seen = 1'b0;
    while (bus.busy_out === 1'b1 && busy_cycles < 200) begin
      if (bus.lookup_ready_out !== 1'b0) ready_seen = 1'b1;
      if (bus.result_valid_out !== 1'b0) result_seen = 1'b1;
      busy_cycles++;
      @(posedge clk);
      #1;
    end
    bus.lookup_valid_in = 1'b0;
    check("flush_busy_cycles", 64'(busy_cycles), 64);
    check("flush_ready_low", ready_seen, 0);
    check("flush_no_result", result_seen, 0);
    check("flush_done_ready", bus.lookup_ready_out, 1);
    do_lookup(6'd0, 20'hAAAAA);
    check("flush_set0_hit", bus.result_hit_out, 0);
    do_lookup(6'd63, 20'hBBBBB);
    check("flush_set63_hit", bus.result_hit_out, 0);
    check("flush_set63_vv", bus.result_victim_valid_out, 0);
    do_lookup(6'd10, 20'h00010);
    check("flush_set10_hit", bus.result_hit_out, 0);

    // Reset during the flush sweep
    do_fill(6'd40, 4'b0001, 20'h40404);
    do_lookup(6'd40, 20'h40404);
    check("set40_hit", bus.result_hit_out, 1);
    @(negedge clk);
    bus.flush_in = 1'b1;
    @(posedge clk);
    #1;
    bus.flush_in = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("midflush_busy", bus.busy_out, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", bus.busy_out, 0);
    check("abort_ready", bus.lookup_ready_out, 1);
    check("abort_result_valid", bus.result_valid_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("post_abort_busy", bus.busy_out, 0);
    do_lookup(6'd40, 20'h40404);
    check("post_abort_hit", bus.result_hit_out, 0);
    check("post_abort_victim", bus.result_victim_out, 4'b0001);
    check("post_abort_vv", bus.result_victim_valid_out, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
